xkbd_ctrl: RTL and testbench
============================

// Module: xkbd_ctrl
// PURPOSE
//  Memory-mapped keyboard peripheral downstream of the PS2 receiver: consumes its code/valid byte stream,
//  folds E0/F0 prefixes into make/break events, queues them in a small FIFO and keeps a held-key bitmap
//  for the game keys. Selected by the address decoder; CPU polls/pops over the xctrl data bus.
// PARAMETERS
//  DATA_W      32  CPU data bus width (from xdefs.vh)
//  FIFO_AW     3   log2 FIFO depth (depth 8)
//  KBD_ADDR_W  2   register address width (4 registers)
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous reset, active-high
//  ps2_code    in   8           scancode byte from PS2 receiver
//  ps2_valid   in   1           one-cycle strobe, ps2_code valid
//  sel         in   1           peripheral select from address decoder
//  we          in   1           1 = write, 0 = read
//  addr        in   KBD_ADDR_W  register index
//  data_in     in   DATA_W      write data
//  data_out    out  DATA_W      read data, combinational from addr/state
// BEHAVIOUR
//  - Single clock clk; reset synchronous, active-high: FIFO empty, overflow=0, keys=0, FSM=IDLE.
//  - Parser FSM (advances only on ps2_valid): IDLE: E0->EXT, F0->BRK, E1/AA/FA/FC/EE dropped, else emit make;
//    EXT: F0->EXT_BRK, else emit ext make ->IDLE; BRK: emit break ->IDLE; EXT_BRK: emit ext break ->IDLE.
//  - Event word: {brk, ext, code[7:0]} (10 bits). Final byte strobe in cycle N -> entry and KEYS visible N+1.
//  - KEYS bitmap set on make, cleared on break: b0 Up(E0 75) b1 Down(E0 72) b2 Left(E0 6B)
//    b3 Right(E0 74) b4 Space(29) b5 Enter(5A); other keys queued only.
//  - Registers: 0 STATUS rd {25'b0, ovf[6], full[5], empty[4], count[3:0]} (count 0..8)
//    1 DATA rd {valid[31], 21'b0, brk[9], ext[8], code[7:0]}; read (sel & ~we) pops at clock edge
//    2 KEYS rd {26'b0, keys[5:0]}
//    3 CTRL wr: data_in[0]=1 flush FIFO, data_in[1]=1 clear ovf; reads return 0.
//  - Writes to 0..2 and reads of 3 have no side effects.
//  - Empty pop: DATA reads 0 (valid=0), no state change.
//  - Full push without pop: event dropped, ovf set (sticky); keys still updated.
//  - Full push + pop same cycle: both happen, count stays 8, no overflow.
//  - Empty push + pop same cycle: pop ignored (reads valid=0), push lands, count=1.
//  - Flush + push same cycle: flush wins, event discarded; keys still updated.
//  - Set ovf + clear ovf same cycle: set wins.
//  - Pointers wrap modulo depth; count kept as FIFO_AW+1 bits.
//  - rst mid-prefix discards partial sequence; no prefix timeout.
// STRUCTURE
//  - Register indices, scancode/prefix constants, key bit positions in shared header xkbd_defs.vh
//    (`KBD_ADDR_W added to xdefs.vh next to `SCORE_ADDR_W); decoder gains kbd_sel.
//  - One sub-module: xkbd_fifo (sync FIFO, push/pop/flush, full/empty/count, 10-bit width).
//  - Parser FSM, keys register and bus mux live in xkbd_ctrl.
// TESTING
//  1 Reset: rst then read STATUS -> 0x10; DATA -> 0; KEYS -> 0.
//  2 Bytes 29, F0 29 -> count=2; DATA pops 0x80000029 then 0x80000229; KEYS b4 high after 29, low after F0 29.
//  3 E0 75 / E0 F0 75 -> pops 0x80000175, 0x80000375; KEYS=0x01 between them; AA and FA alone -> nothing queued.
//  4 Nine make codes 1C..24 without reads -> STATUS 0x68; pops 1C..23 in order; 24 lost; CTRL write 2 -> ovf=0.
//  5 FIFO full, final byte strobe coincident with DATA pop -> count stays 8, ovf=0; empty + same -> count=1.
//  6 rst asserted after E0, then 6B -> plain make 0x8000006B queued, KEYS b2 stays 0; flush(1) + push same cycle -> count=0.

Source files
------------

// File: rtl/xkbd_pkg.sv
// Shared types and constants for the keyboard peripheral: bus widths, register map,
// scancode prefixes, game-key positions and the queued event layout.
package xkbd_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_AW    = 3;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W      = FIFO_AW + 1;
  localparam int unsigned KBD_ADDR_W = 2;
  localparam int unsigned CODE_W     = 8;
  localparam int unsigned EVT_W      = CODE_W + 2;
  localparam int unsigned NUM_KEYS   = 6;

  localparam logic [KBD_ADDR_W-1:0] REG_STATUS = 2'd0;
  localparam logic [KBD_ADDR_W-1:0] REG_DATA   = 2'd1;
  localparam logic [KBD_ADDR_W-1:0] REG_KEYS   = 2'd2;
  localparam logic [KBD_ADDR_W-1:0] REG_CTRL   = 2'd3;

  localparam logic [CODE_W-1:0] SC_EXT     = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BRK     = 8'hF0;
  localparam logic [CODE_W-1:0] SC_PAUSE   = 8'hE1;
  localparam logic [CODE_W-1:0] SC_BAT_OK  = 8'hAA;
  localparam logic [CODE_W-1:0] SC_ACK     = 8'hFA;
  localparam logic [CODE_W-1:0] SC_BAT_ERR = 8'hFC;
  localparam logic [CODE_W-1:0] SC_ECHO    = 8'hEE;

  localparam logic [CODE_W-1:0] SC_UP    = 8'h75;
  localparam logic [CODE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [CODE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [CODE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [CODE_W-1:0] SC_SPACE = 8'h29;
  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_SPACE = 4;
  localparam int unsigned KEY_ENTER = 5;

  typedef struct packed {
    logic              brk;
    logic              ext;
    logic [CODE_W-1:0] code;
  } kbd_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  // Controller housekeeping bytes that never become key events.
  function automatic logic is_dropped(input logic [CODE_W-1:0] code);
    return (code == SC_PAUSE) || (code == SC_BAT_OK) || (code == SC_ACK) ||
           (code == SC_BAT_ERR) || (code == SC_ECHO);
  endfunction

  // One-hot game-key bit for an event, zero for keys that are only queued.
  function automatic logic [NUM_KEYS-1:0] key_mask(input kbd_evt_t evt);
    logic [NUM_KEYS-1:0] mask;
    mask = '0;
    if (evt.ext) begin
      if (evt.code == SC_UP)    mask[KEY_UP]    = 1'b1;
      if (evt.code == SC_DOWN)  mask[KEY_DOWN]  = 1'b1;
      if (evt.code == SC_LEFT)  mask[KEY_LEFT]  = 1'b1;
      if (evt.code == SC_RIGHT) mask[KEY_RIGHT] = 1'b1;
    end else begin
      if (evt.code == SC_SPACE) mask[KEY_SPACE] = 1'b1;
      if (evt.code == SC_ENTER) mask[KEY_ENTER] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/xkbd_if.sv
// CPU-side register bus of the keyboard peripheral.
interface xkbd_if;
  import xkbd_pkg::*;

  logic                  sel;
  logic                  we;
  logic [KBD_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]     data_out;

  modport master (output sel, we, addr, data_in, input data_out);
  modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xkbd_fifo.sv
// Synchronous event FIFO with flush; a pop on an empty FIFO is ignored and a push
// into a full FIFO only lands when a pop frees a slot in the same cycle.
module xkbd_fifo
  import xkbd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  kbd_evt_t         wr_data,
  output kbd_evt_t         rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  kbd_evt_t             mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 pop_ok;
  logic                 push_ok;

  assign empty_c   = (count == '0);
  assign full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign pop_ok    = pop & ~empty_c;
  assign push_ok   = push & (~full_c | pop_ok);
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/xkbd_ctrl.sv
// Keyboard peripheral: folds E0/F0 prefixes into make/break events, queues them,
// tracks held game keys and serves the STATUS/DATA/KEYS/CTRL registers.
module xkbd_ctrl
  import xkbd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] ps2_code,
  input  logic              ps2_valid,
  xkbd_if.slave             bus
);

  parse_state_t        state, state_nxt;
  logic                evt_vld_c;
  kbd_evt_t            evt_c;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] mask_c;
  logic                ovf;

  kbd_evt_t            head_c;
  logic                full_c, empty_c;
  logic [CNT_W-1:0]    count;

  logic rd_c, wr_ctrl_c, pop_c, flush_c, ovf_clr_c, ovf_set_c;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Prefix parser: only the final byte of a sequence produces an event.
  always_comb begin
    state_nxt = state;
    evt_vld_c = 1'b0;
    evt_c     = '{brk: 1'b0, ext: 1'b0, code: ps2_code};
    if (ps2_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (ps2_code == SC_EXT)      state_nxt = ST_EXT;
          else if (ps2_code == SC_BRK) state_nxt = ST_BRK;
          else if (!is_dropped(ps2_code)) evt_vld_c = 1'b1;
        end
        ST_EXT: begin
          if (ps2_code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            evt_vld_c = 1'b1;
            evt_c.ext = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          evt_vld_c = 1'b1;
          evt_c.brk = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          evt_vld_c = 1'b1;
          evt_c.brk = 1'b1;
          evt_c.ext = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rd_c      = bus.sel & ~bus.we;
  assign wr_ctrl_c = bus.sel & bus.we & (bus.addr == REG_CTRL);
  assign pop_c     = rd_c & (bus.addr == REG_DATA);
  assign flush_c   = wr_ctrl_c & bus.data_in[0];
  assign ovf_clr_c = wr_ctrl_c & bus.data_in[1];
  assign ovf_set_c = evt_vld_c & full_c & ~(pop_c & ~empty_c) & ~flush_c;
  assign mask_c    = key_mask(evt_c);

  xkbd_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_vld_c),
    .pop       (pop_c),
    .flush     (flush_c),
    .wr_data   (evt_c),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .count     (count)
  );

  // Keys follow every event, even ones the FIFO drops or flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys <= '0;
      ovf  <= 1'b0;
    end else begin
      if (evt_vld_c) keys <= evt_c.brk ? (keys & ~mask_c) : (keys | mask_c);
      if (ovf_set_c)      ovf <= 1'b1;
      else if (ovf_clr_c) ovf <= 1'b0;
    end
  end

  always_comb begin
    bus.data_out = '0;
    unique case (bus.addr)
      REG_STATUS: bus.data_out = {25'b0, ovf, full_c, empty_c, count};
      REG_DATA:   bus.data_out = empty_c ? '0 : {1'b1, 21'b0, head_c};
      REG_KEYS:   bus.data_out = {26'b0, keys};
      default:    bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_xkbd_ctrl.sv
// Directed bench for xkbd_ctrl: reads queue their expected value, a negedge monitor checks them.
module tb_xkbd_ctrl;
  import xkbd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_code;
  logic       ps2_valid;

  xkbd_if bus ();

  xkbd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_code  (ps2_code),
    .ps2_valid (ps2_valid),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Scoreboard monitor: every CPU read cycle consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && bus.sel && !bus.we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: addr %0d got %08h, no expectation queued", bus.addr, bus.data_out);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL %s: got %08h want %08h", n, bus.data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with an optional scancode byte, an optional read and an optional write.
  task automatic step(input bit vb, input logic [7:0] b,
                      input bit rd, input bit wr, input logic [1:0] a,
                      input logic [31:0] val, input string nm);
    ps2_valid   = vb;
    ps2_code    = b;
    bus.sel     = rd | wr;
    bus.we      = wr;
    bus.addr    = a;
    bus.data_in = wr ? val : 32'h0;
    if (rd) begin
      exp_q.push_back(val);
      name_q.push_back(nm);
    end
    tick();
    ps2_valid = 1'b0;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 2'd0, 32'h0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    step(1'b0, 8'h00, 1'b1, 1'b0, a, e, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    step(1'b0, 8'h00, 1'b0, 1'b1, a, v, "");
  endtask

  initial begin
    rst = 1'b1; ps2_code = 8'h00; ps2_valid = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.data_in = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd(REG_STATUS, 32'h10, "reset_status");
    rd(REG_DATA,   32'h0,  "reset_data");
    rd(REG_KEYS,   32'h0,  "reset_keys");
    rd(REG_DATA,   32'h0,  "empty_pop");
    rd(REG_STATUS, 32'h10, "empty_pop_status");
    rd(REG_CTRL,   32'h0,  "ctrl_reads_zero");

    // Plain make / break of Space
    send(8'h29);
    rd(REG_KEYS, 32'h10, "space_held");
    send(8'hF0); send(8'h29);
    rd(REG_KEYS,   32'h00, "space_released");
    rd(REG_STATUS, 32'h02, "two_queued");
    wr(REG_DATA, 32'hFFFF_FFFF);
    wr(REG_STATUS, 32'hFFFF_FFFF);
    rd(REG_STATUS, 32'h02, "write_no_side_effect");
    rd(REG_DATA, 32'h8000_0029, "pop_space_make");
    rd(REG_DATA, 32'h8000_0229, "pop_space_break");

    // Extended Up make / break, housekeeping bytes dropped
    send(8'hE0); send(8'h75);
    rd(REG_KEYS, 32'h01, "up_held");
    send(8'hE0); send(8'hF0); send(8'h75);
    rd(REG_KEYS, 32'h00, "up_released");
    rd(REG_DATA, 32'h8000_0175, "pop_up_make");
    rd(REG_DATA, 32'h8000_0375, "pop_up_break");
    send(8'hAA); send(8'hFA);
    rd(REG_STATUS, 32'h10, "housekeeping_dropped");

    // Overflow: nine makes, ninth lost
    for (int i = 0; i < 9; i++) send(8'(8'h1C + i));
    rd(REG_STATUS, 32'h68, "overflow_status");
    for (int i = 0; i < 8; i++) rd(REG_DATA, 32'h8000_0000 | (32'h1C + 32'(i)), "overflow_pop_order");
    rd(REG_STATUS, 32'h50, "ovf_sticky_when_empty");
    wr(REG_CTRL, 32'h2);
    rd(REG_STATUS, 32'h10, "ovf_cleared");

    // Full FIFO: push coincident with pop
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    rd(REG_STATUS, 32'h28, "fifo_full");
    step(1'b1, 8'h38, 1'b1, 1'b0, REG_DATA, 32'h8000_0030, "full_push_pop_data");
    rd(REG_STATUS, 32'h28, "full_push_pop_status");
    for (int i = 1; i < 9; i++) rd(REG_DATA, 32'h8000_0030 + 32'(i), "drain_after_full_push_pop");
    rd(REG_STATUS, 32'h10, "drained");

    // Empty FIFO: push coincident with pop
    step(1'b1, 8'h39, 1'b1, 1'b0, REG_DATA, 32'h0, "empty_push_pop_data");
    rd(REG_STATUS, 32'h01, "empty_push_pop_status");
    rd(REG_DATA, 32'h8000_0039, "empty_push_pop_entry");

    // Overflow set and clear in the same cycle: set wins; then flush + clear
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i));
    step(1'b1, 8'h48, 1'b0, 1'b1, REG_CTRL, 32'h2, "");
    rd(REG_STATUS, 32'h68, "ovf_set_beats_clear");
    wr(REG_CTRL, 32'h3);
    rd(REG_STATUS, 32'h10, "flush_and_clear");

    // Reset mid-prefix discards the pending E0
    send(8'hE0);
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h6B);
    rd(REG_STATUS, 32'h01, "after_rst_prefix_status");
    rd(REG_KEYS,   32'h00, "after_rst_prefix_keys");
    rd(REG_DATA,   32'h8000_006B, "after_rst_plain_make");

    // Flush + push same cycle: event discarded, keys still updated
    step(1'b1, 8'h5A, 1'b0, 1'b1, REG_CTRL, 32'h1, "");
    rd(REG_STATUS, 32'h10, "flush_beats_push");
    rd(REG_KEYS,   32'h20, "enter_held_after_flush");
    send(8'hF0); send(8'h5A);
    rd(REG_KEYS,   32'h00, "enter_released");
    rd(REG_DATA,   32'h8000_025A, "pop_enter_break");

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
